eu_iqueue: RTL



---
 rtl/pkg_dtypes.sv | 38 +++
 rtl/design_parameters.sv | 12 +
 rtl/eu_iqueue_ctrl.sv | 95 +++++++++
 rtl/eu_iqueue.sv | 80 ++++++++
 4 files changed

// File: rtl/pkg_dtypes.sv
// ============================================================================
//  pkg_dtypes
//  Shared datapath types for dispatch, instruction queues and EU operand caches.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package pkg_dtypes;

    typedef enum logic [1:0] {
        OPM_REG  = 2'd0,
        OPM_IMM  = 2'd1,
        OPM_NONE = 2'd2,
        OPM_FWD  = 2'd3
    } type_opd_mode;

    typedef struct packed {
        logic [5:0]   opcode;
        type_opd_mode op0m;
        type_opd_mode op1m;
        logic [15:0]  imm;
        logic [2:0]   euidx;
        logic [4:0]   dst;
    } type_iqueue_entry;

    // Non-REG operand modes keep the cache's ybuf/xbuf requests quiet while idle.
    localparam type_iqueue_entry IQ_IDLE_ENTRY = '{
        opcode: 6'd0,
        op0m:   OPM_NONE,
        op1m:   OPM_NONE,
        imm:    16'd0,
        euidx:  3'd0,
        dst:    5'd0
    };

endpackage : pkg_dtypes

`default_nettype wire

// File: rtl/design_parameters.sv
// ============================================================================
//  design_parameters
//  Project-wide default sizing constants shared across the EU blocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef EU_IQUEUE_DEPTH
`define EU_IQUEUE_DEPTH 8
`endif

`default_nettype wire

// File: rtl/eu_iqueue_ctrl.sv
// ============================================================================
//  eu_iqueue_ctrl
//  Pointer, occupancy, flag and head-age bookkeeping for the EU instruction queue.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module eu_iqueue_ctrl #(
    parameter int DEPTH = 8,
    parameter int AGE_W = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push_req,
    input  logic             i_pop_req,
    input  logic             i_flush,
    output logic             o_push_en,
    output logic [PTR_W-1:0] o_wptr,
    output logic [PTR_W-1:0] o_rptr,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_ready,
    output logic             o_curr_valid,
    output logic [AGE_W-1:0] o_head_age
);

    localparam logic [AGE_W-1:0] c_age_max = {AGE_W{1'b1}};
    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] w_age_next;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // Acceptance depends on full only, so a popping full queue still refuses this cycle.
    assign w_push = i_push_req & ~w_full  & ~i_flush;
    assign w_pop  = i_pop_req  & ~w_empty & ~i_flush;

    always_comb begin
        w_age_next = r_age;
        if (w_pop) begin
            w_age_next = '0;
        end else if (w_empty) begin
            w_age_next = w_push ? AGE_W'(1) : '0;
        end else if (r_age != c_age_max) begin
            w_age_next = r_age + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_age   <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
            r_age <= w_age_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (r_count <= c_depth);
            assert (!(w_push && w_full));
        end
    end

    assign o_push_en    = w_push;
    assign o_wptr       = r_wptr;
    assign o_rptr       = r_rptr;
    assign o_count      = r_count;
    assign o_empty      = w_empty;
    assign o_full       = w_full;
    assign o_ready      = ~w_full;
    assign o_curr_valid = ~w_empty;
    assign o_head_age   = r_age;

endmodule : eu_iqueue_ctrl

`default_nettype wire

// File: rtl/eu_iqueue.sv
// ============================================================================
//  eu_iqueue
//  In-order per-EU instruction FIFO feeding the operand cache; head retires on store.
//  Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef EU_IQUEUE_DEPTH
`define EU_IQUEUE_DEPTH 8
`endif

module eu_iqueue
    import pkg_dtypes::*;
#(
    parameter int EU_IDX = 0,
    parameter int DEPTH  = `EU_IQUEUE_DEPTH,
    parameter int AGE_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  type_iqueue_entry          disp_instr_i,
    input  logic                      disp_valid_i,
    output logic                      disp_ready_o,
    output type_iqueue_entry          curr_instr_o,
    output logic                      curr_valid_o,
    input  logic                      instr_done_i,
    input  logic                      flush_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic [AGE_W-1:0]          head_age_o
);

    localparam int c_ptr_w = $clog2(DEPTH);

    type_iqueue_entry   r_mem [DEPTH];
    logic               w_push_en;
    logic [c_ptr_w-1:0] w_wptr;
    logic [c_ptr_w-1:0] w_rptr;
    logic               w_curr_valid;

    eu_iqueue_ctrl #(
        .DEPTH (DEPTH),
        .AGE_W (AGE_W)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .i_push_req   (disp_valid_i),
        .i_pop_req    (instr_done_i),
        .i_flush      (flush_i),
        .o_push_en    (w_push_en),
        .o_wptr       (w_wptr),
        .o_rptr       (w_rptr),
        .o_count      (count_o),
        .o_empty      (empty_o),
        .o_full       (full_o),
        .o_ready      (disp_ready_o),
        .o_curr_valid (w_curr_valid),
        .o_head_age   (head_age_o)
    );

    // Storage is deliberately not reset; validity lives entirely in the count.
    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[w_wptr] <= disp_instr_i;
    end

    // Head is read from registered memory and pointer, never from the dispatch inputs.
    always_comb begin
        curr_instr_o = IQ_IDLE_ENTRY;
        if (w_curr_valid) begin
            curr_instr_o       = r_mem[w_rptr];
            curr_instr_o.euidx = 3'(EU_IDX);
        end
    end

    assign curr_valid_o = w_curr_valid;

endmodule : eu_iqueue

`default_nettype wire
